uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter between two byte requesters: req0 = core MMIO store path, req1 = debug/monitor.
//  Each requester has its own FIFO. The downstream transmitter uses the existing tx_data/tx_data_valid/tx_data_ready handshake.
//  Arbitration is round-robin, with a message lock: a granted requester keeps the UART until it sends a byte with last=1,
//  or until its lock times out, so strings from the two requesters never interleave.
// PARAMETERS
//  FIFO_DEPTH    4     entries per requester FIFO; power of 2, >=2
//  LOCK_TIMEOUT  2340  consecutive cycles with the owner FIFO empty before the lock is forcibly released (~10 bit times at 27 MHz/115200); >=1
// PORTS
//  clk            in   1  system clock
//  rst            in   1  synchronous, active-high reset
//  req0_data      in   8  byte from requester 0
//  req0_last      in   1  byte ends requester-0 message; releases lock after it is sent
//  req0_valid     in   1  requester 0 offers a byte
//  req0_ready     out  1  FIFO0 accepts the byte (= !full0 && !rst)
//  req1_data      in   8  byte from requester 1
//  req1_last      in   1  as req0_last, for requester 1
//  req1_valid     in   1  requester 1 offers a byte
//  req1_ready     out  1  = !full1 && !rst
//  tx_data        out  8  byte to the UART transmitter (head of the owner FIFO)
//  tx_data_valid  out  1  tx_data is valid
//  tx_data_ready  in   1  transmitter accepts the byte
//  grant          out  2  one-hot owner: 01 = req0, 10 = req1, 00 = idle
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - both FIFOs empty; state=IDLE; last_served=1 (req0 wins the first tie); timeout counter=0.
//   - outputs: tx_data_valid=0, grant=00, tx_data=8'h00, reqN_ready=0 while rst is high.
//  FIFOs:
//   - 9-bit entries {last,data}. Push when reqN_valid && reqN_ready.
//   - Pop when the FIFO is the owner and tx_data_valid && tx_data_ready.
//   - Push and pop in the same cycle on a non-empty FIFO: both occur, count unchanged.
//   - Full FIFO: ready=0 even if a pop occurs that cycle; no overwrite, no loss.
//   - Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
//  FSM states: IDLE, GRANT0, GRANT1 (registered).
//   - IDLE -> GRANTn if only FIFOn is non-empty.
//   - IDLE with both non-empty -> GRANT to !last_served.
//   - IDLE with both empty -> stay.
//   - GRANTn: tx_data_valid = !emptyN; tx_data = headN data (8'h00 when empty).
//   - GRANTn: on handshake of an entry with last=1 -> IDLE, last_served<=n.
//   - GRANTn with FIFOn empty: valid=0, lock held, timeout counter increments.
//     The counter clears on any cycle FIFOn is non-empty.
//     On LOCK_TIMEOUT consecutive empty cycles -> IDLE, last_served<=n.
//  Latency: push at edge k into an empty FIFO in IDLE -> grant at edge k+1 -> tx_data_valid high in the cycle after edge k+1.
//  Back-to-back: while in GRANTn with data queued, one byte per cycle when tx_data_ready=1. IDLE costs 1 cycle between messages.
//  Stability: while tx_data_valid && !tx_data_ready, tx_data and grant hold. Valid never drops without a handshake, except on rst.
//  Reset mid-message: everything is flushed within the reset cycle. Queued bytes are discarded; no partial byte is presented afterwards.
//  grant = one-hot of state, registered; 00 in IDLE.
// TESTING
//  - Reset then idle: rst 2 cycles -> valid=0, grant=00; req0/1_ready=1 on the first cycle after rst.
//  - Single byte: req0 pushes 8'h41 last=1, ready tied 1 -> valid high 2 cycles later with 8'h41; grant 01 then 00.
//  - Lock: req0 sends "AB"+last on 'C', req1 concurrently sends 'x','y'(last) -> tx order A,B,C,x,y; no interleave.
//  - Round-robin tie: both FIFOs loaded from reset -> req0 first; next tie from IDLE -> req1.
//  - Full/backpressure: tx_data_ready=0, push 5 bytes to req0 at FIFO_DEPTH=4 -> req0_ready=0 after the 4th.
//    tx_data stays on byte0; on release all 4 bytes go out in order; 5th is retried.
//  - Timeout: req0 sends 1 byte with last=0 then stops, req1 waiting -> grant stays 01 for 2340 empty cycles, then moves to 10.
//    Mid-message rst -> FIFOs empty, valid=0 next cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between two byte requesters.
// Each requester has its own FIFO. The owner keeps the UART until it sends a byte with last=1, or until its lock times out.

module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [8:0] din,
    input  logic       pop,
    output logic [8:0] head,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;

    // The caller only pushes when the FIFO is not full and only pops when it is not empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    assign head  = mem[rp];
    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));
endmodule

module uart_tx_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int LOCK_TIMEOUT = 2340
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       tx_data_valid,
    input  logic       tx_data_ready,
    output logic [1:0] grant
);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t        state, state_n;
    logic          last_served, last_served_n;
    logic [TW-1:0] tmo_cnt, tmo_cnt_n;

    logic [1:0]      push, pop, empty, full, ready;
    logic [1:0][8:0] din, head;
    logic            own, own_empty, hs;
    logic [8:0]      own_head;

    assign din[0] = {req0_last, req0_data};
    assign din[1] = {req1_last, req1_data};
    assign ready  = ~full & {2{~rst}};
    assign push   = {req1_valid, req0_valid} & ready;

    for (genvar i = 0; i < 2; i++) begin : g_fifo
        uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .din   (din[i]),
            .pop   (pop[i]),
            .head  (head[i]),
            .empty (empty[i]),
            .full  (full[i])
        );
    end

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

    assign own       = (state == GRANT1);
    assign own_empty = empty[own];
    assign own_head  = head[own];

    // Valid is gated by rst so nothing is presented while a flush is pending.
    assign tx_data_valid = (state != IDLE) && !own_empty && !rst;
    assign tx_data       = tx_data_valid ? own_head[7:0] : 8'h00;
    assign hs            = tx_data_valid && tx_data_ready;
    assign pop           = {hs && (state == GRANT1), hs && (state == GRANT0)};
    assign grant         = {state == GRANT1, state == GRANT0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_served <= 1'b1;
            tmo_cnt     <= '0;
        end else begin
            state       <= state_n;
            last_served <= last_served_n;
            tmo_cnt     <= tmo_cnt_n;
        end
    end

    always_comb begin
        state_n       = state;
        last_served_n = last_served;
        tmo_cnt_n     = tmo_cnt;
        case (state)
            IDLE: begin
                tmo_cnt_n = '0;
                if (!empty[0] && !empty[1]) state_n = last_served ? GRANT0 : GRANT1;
                else if (!empty[0])         state_n = GRANT0;
                else if (!empty[1])         state_n = GRANT1;
            end
            GRANT0, GRANT1: begin
                if (own_empty) begin
                    // Owner went quiet mid-message: hold the lock, but not forever.
                    if (tmo_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                        state_n       = IDLE;
                        last_served_n = own;
                        tmo_cnt_n     = '0;
                    end else begin
                        tmo_cnt_n = tmo_cnt + TW'(1);
                    end
                end else begin
                    tmo_cnt_n = '0;
                    if (hs && own_head[8]) begin
                        state_n       = IDLE;
                        last_served_n = own;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
